// File: rtl/ovf_accum_ctrl_if.sv
// rtl/ovf_accum_ctrl_if.sv - job control, operand and result streams for ovf_accum_ctrl
interface ovf_accum_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             sat_en;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output start, len, sat_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy, ovf_count
  );

  modport slave (
    input  start, len, sat_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy, ovf_count
  );
endinterface

// File: rtl/ovf_accum_ctrl.sv
// rtl/ovf_accum_ctrl.sv - signed accumulate-with-overflow job sequencer
// Saturating or wrapping accumulation per job, cumulative saturating overflow counter.
module ovf_accum_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  ovf_accum_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             job_ovf_q, job_ovf_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  always_comb begin
    sum = acc_q + bus.in_data;
    // Same-sign operands whose result flips sign have left the representable range.
    ovf = (acc_q[WIDTH-1] == bus.in_data[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);

    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    job_ovf_d   = job_ovf_q;
    sat_d       = sat_q;
    ovf_count_d = ovf_count_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d     = '0;
          job_ovf_d = 1'b0;
          if (bus.len != '0) begin
            remaining_d = bus.len;
            sat_d       = bus.sat_en;
            state_d     = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          if (ovf && sat_q) begin
            acc_d = acc_q[WIDTH-1] ? MOST_NEG : MOST_POS;
          end else begin
            acc_d = sum;
          end
          if (ovf) begin
            job_ovf_d = 1'b1;
            if (ovf_count_q != '1) begin
              ovf_count_d = ovf_count_q + 1'b1;
            end
          end
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      job_ovf_q   <= 1'b0;
      sat_q       <= 1'b0;
      ovf_count_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      job_ovf_q   <= job_ovf_d;
      sat_q       <= sat_d;
      ovf_count_q <= ovf_count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = job_ovf_q;
  assign bus.busy      = busy_q;
  assign bus.ovf_count = ovf_count_q;
endmodule

// File: tb/tb_ovf_accum_ctrl.sv
// tb/tb_ovf_accum_ctrl.sv - self-checking bench for ovf_accum_ctrl
module tb_ovf_accum_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  ovf_accum_ctrl_if #(.WIDTH(8), .LEN_W(4), .CNT_W(8)) bus ();

  ovf_accum_ctrl #(.WIDTH(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: phase 0 idle, 1 collecting operands, 2 result held.
  int m_phase, m_acc, m_rem, m_cnt;
  bit m_jovf, m_sat;

  always @(posedge clk or posedge rst) begin
    int s;
    if (rst) begin
      m_phase = 0; m_acc = 0; m_rem = 0; m_cnt = 0; m_jovf = 0; m_sat = 0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          m_acc = 0; m_jovf = 0;
          if (bus.len != 0) begin
            m_rem = int'(bus.len); m_sat = bus.sat_en; m_phase = 1;
          end else m_phase = 2;
        end
        1: if (bus.in_valid) begin
          s = m_acc + int'($signed(bus.in_data));
          if (s > 127 || s < -128) begin
            m_jovf = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_sat) s = (s > 127) ? 127 : -128;
            else s = (s > 127) ? s - 256 : s + 256;
          end
          m_acc = s;
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", int'(bus.busy), int'(m_phase != 0));
      chk("in_ready", int'(bus.in_ready), int'(m_phase == 1));
      chk("out_valid", int'(bus.out_valid), int'(m_phase == 2));
      chk("ovf_count", int'(bus.ovf_count), m_cnt);
      if (m_phase == 2) begin
        chk("out_data", int'($signed(bus.out_data)), m_acc);
        chk("out_ovf", int'(bus.out_ovf), int'(m_jovf));
      end
    end
  end

  task automatic start_job(input int l, input bit s);
    bus.start = 1'b1; bus.len = 4'(l); bus.sat_en = s;
    @(negedge clk);
    bus.start = 1'b0; bus.len = 4'($urandom); bus.sat_en = 1'($urandom);
  endtask

  task automatic feed(input int d, input bit gap);
    int budget = 50;
    while (!bus.in_ready && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) chk("feed_timeout", 0, 1);
    bus.in_valid = 1'b1; bus.in_data = 8'(d);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
    if (gap) @(negedge clk);
  endtask

  task automatic get_result(input int hold, output int d, output int o);
    int budget = 50;
    while (!bus.out_valid && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) chk("result_timeout", 0, 1);
    d = int'($signed(bus.out_data)); o = int'(bus.out_ovf);
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int d, o, first;
    bus.start = 0; bus.len = 0; bus.sat_en = 0; bus.in_valid = 0;
    bus.in_data = 0; bus.out_ready = 0;
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_ovf", int'(bus.out_ovf), 0);
    chk("rst_ovf_count", int'(bus.ovf_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_job(3, 0);
    feed(10, 0); feed(20, 0); feed(30, 0);
    chk("t1_latency", int'(bus.out_valid), 1);
    get_result(0, d, o);
    chk("t1_data", d, 60); chk("t1_ovf", o, 0);
    chk("t1_cnt", int'(bus.ovf_count), 0);

    start_job(2, 1); feed(100, 0); feed(100, 0); get_result(0, d, o);
    chk("t2_data", d, 127); chk("t2_ovf", o, 1);
    chk("t2_cnt", int'(bus.ovf_count), 1);
    start_job(2, 1); feed(-100, 0); feed(-100, 0); get_result(0, d, o);
    chk("t2n_data", d, -128); chk("t2n_cnt", int'(bus.ovf_count), 2);

    start_job(2, 0); feed(100, 0); feed(100, 0); get_result(0, d, o);
    chk("t3_data", d, -56); chk("t3_ovf", o, 1);
    start_job(2, 0); feed(127, 0); feed(-1, 0); get_result(0, d, o);
    chk("t3m_data", d, 126); chk("t3m_ovf", o, 0);
    chk("t3m_cnt", int'(bus.ovf_count), 3);

    start_job(4, 0);
    feed(1, 1);
    bus.start = 1'b1; bus.len = 4'd1;
    feed(2, 1);
    bus.start = 1'b0;
    feed(3, 1); feed(4, 0);
    bus.start = 1'b1; bus.len = 4'd1;
    first = int'($signed(bus.out_data));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_data", int'($signed(bus.out_data)), first);
    end
    bus.start = 1'b0;
    get_result(0, d, o);
    chk("t4_data", d, 10);
    @(negedge clk);
    chk("t4_no_extra", int'(bus.busy), 0);

    start_job(0, 1);
    chk("len0_valid", int'(bus.out_valid), 1);
    chk("len0_data", int'(bus.out_data), 0);
    chk("len0_ovf", int'(bus.out_ovf), 0);
    get_result(0, d, o);

    for (int j = 0; j < 40; j++) begin
      int l = $urandom_range(0, 6);
      start_job(l, 1'($urandom));
      for (int k = 0; k < l; k++) feed(int'($urandom_range(0, 255)), 1'($urandom));
      get_result($urandom_range(0, 3), d, o);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int j = 0; j < 300; j++) begin
      start_job(2, 0); feed(100, 0); feed(100, 0); get_result(0, d, o);
    end
    chk("sat_cnt", int'(bus.ovf_count), 255);
    chk("sat_job_ovf", o, 1);

    start_job(4, 0); feed(7, 0); feed(9, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_in_ready", int'(bus.in_ready), 0);
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_cnt", int'(bus.ovf_count), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_job(1, 0); feed(-5, 0); get_result(0, d, o);
    chk("post_rst_data", d & 255, 8'hFB);
    chk("post_rst_ovf", o, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
